// File: rtl/servo_pose_sequencer.sv
// servo_pose_sequencer
//   Holds a six-joint target pose and slews the live PWM on-times toward it by at
//   most STEP counts per servo frame, so the servos never jump between poses.
//   Optional feature macro: SERVO_ESTOP_EN adds an active-high "estop" input that
//   freezes the live on-times, suppresses done and pose_ready, and holds the state.
module servo_pose_sequencer #(
  parameter int NUM_JOINTS   = 6,
  parameter int WIDTH        = 28,
  parameter int FRAME_CYCLES = 2000000,
  parameter int STEP         = 1000,
  parameter int MIN_ON       = 100000,
  parameter int MAX_ON       = 250000
) (
  input  logic                        clk,
  input  logic                        rst_n,
`ifdef SERVO_ESTOP_EN
  input  logic                        estop,
`endif
  input  logic                        pose_valid,
  output logic                        pose_ready,
  input  logic [NUM_JOINTS*WIDTH-1:0] pose_on_time,
  output logic [NUM_JOINTS*WIDTH-1:0] on_time_bus,
  output logic                        frame_tick,
  output logic                        busy,
  output logic                        done
);

  localparam int CW = $clog2(FRAME_CYCLES + 1);
  localparam int BW = NUM_JOINTS * WIDTH;
  localparam logic [WIDTH-1:0] ZERO_ON = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] STEP_ON = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(MIN_ON);
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_ON);
  localparam logic [CW-1:0]    LAST_CNT = CW'(FRAME_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RAMP = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            frame_tick_q, frame_tick_d;
  logic [BW-1:0]   tgt_q, tgt_d;
  logic [BW-1:0]   cur_q, cur_d;
  logic [BW-1:0]   stepped_s;
  logic            all_match_s;
  logic            hold_s;
  logic            pose_ready_s;
  logic            done_s;

  // Zero means "joint disabled"; any other request is forced into the safe servo range.
  function automatic logic [WIDTH-1:0] clamp_on(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v == ZERO_ON)    r = ZERO_ON;
    else if (v < MIN_V)  r = MIN_V;
    else if (v > MAX_V)  r = MAX_V;
    else                 r = v;
    return r;
  endfunction

  // One frame's move: disable, jump on first pulse, or bounded step without overshoot.
  function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt);
    logic [WIDTH-1:0] r;
    if (tgt == ZERO_ON)      r = ZERO_ON;
    else if (cur == ZERO_ON) r = tgt;
    else if (cur < tgt)      r = ((tgt - cur) > STEP_ON) ? (cur + STEP_ON) : tgt;
    else if (cur > tgt)      r = ((cur - tgt) > STEP_ON) ? (cur - STEP_ON) : tgt;
    else                     r = cur;
    return r;
  endfunction

`ifdef SERVO_ESTOP_EN
  assign hold_s = estop;
`else
  assign hold_s = 1'b0;
`endif

  // Free-running frame counter; the tick flop is high exactly while count is at its last value.
  always_comb begin
    cnt_d        = cnt_q;
    frame_tick_d = 1'b0;
    if (cnt_q == LAST_CNT) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    frame_tick_d = (cnt_d == LAST_CNT);
  end

  // Candidate per-joint update for this frame and whether it lands every joint on target.
  always_comb begin
    stepped_s   = {BW{1'b0}};
    all_match_s = 1'b1;
    for (int j = 0; j < NUM_JOINTS; j++) begin
      stepped_s[j*WIDTH +: WIDTH] = step_toward(cur_q[j*WIDTH +: WIDTH], tgt_q[j*WIDTH +: WIDTH]);
      if (stepped_s[j*WIDTH +: WIDTH] != tgt_q[j*WIDTH +: WIDTH]) begin
        all_match_s = 1'b0;
      end else begin
        all_match_s = all_match_s;
      end
    end
  end

  // Sequencer FSM: latch clamped targets in IDLE, step live values on ticks in RAMP.
  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    cur_d        = cur_q;
    done_s       = 1'b0;
    pose_ready_s = (state_q == S_IDLE) && !hold_s;
    case (state_q)
      S_IDLE: begin
        if (pose_valid && pose_ready_s) begin
          for (int j = 0; j < NUM_JOINTS; j++) begin
            tgt_d[j*WIDTH +: WIDTH] = clamp_on(pose_on_time[j*WIDTH +: WIDTH]);
          end
          state_d = S_RAMP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RAMP: begin
        if (frame_tick_q && !hold_s) begin
          cur_d = stepped_s;
          if (all_match_s) begin
            done_s  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_RAMP;
          end
        end else begin
          state_d = S_RAMP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, targets, live on-times and frame timing; reset aborts any move in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CW{1'b0}};
      frame_tick_q <= 1'b0;
      tgt_q        <= {BW{1'b0}};
      cur_q        <= {BW{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frame_tick_q <= frame_tick_d;
      tgt_q        <= tgt_d;
      cur_q        <= cur_d;
    end
  end

  assign on_time_bus = cur_q;
  assign frame_tick  = frame_tick_q;
  assign busy        = (state_q == S_RAMP);
  assign pose_ready  = pose_ready_s;
  assign done        = done_s;

endmodule
